// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped instruction cache with a blocking miss FSM.
// A miss holds memoryAddress for MEM_LATENCY edges, then captures memoryLine into the latched line.
module instruction_cache #(
    parameter int LINES = 16,
    parameter int MEM_LATENCY = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  pcAddress,
    input  logic [127:0] memoryLine,
    output logic [31:0]  memoryAddress,
    output logic [31:0]  instruction,
    output logic         hit,
    output logic         stall
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;
    localparam int CW = $clog2(MEM_LATENCY);
    typedef enum logic {LOOKUP, WAIT} state_t;
    state_t state, next;
    logic [LINES-1:0] valid;
    logic [TW-1:0] tags [LINES];
    logic [127:0] lines [LINES];
    logic [IW-1:0] index, fillIndex;
    logic [TW-1:0] tag, fillTag;
    logic [CW-1:0] count;
    logic [127:0] line;
    logic [1:0] slot;
    logic fill;
    assign index = pcAddress[4 +: IW];
    assign tag = pcAddress[31 -: TW];
    assign line = lines[index];
    // word 0 sits in the MSBs, so the slice position counts down from the top
    assign slot = ~pcAddress[3:2];
    assign stall = ~hit;
    always_comb begin
        hit = state == LOOKUP && valid[index] && tags[index] == tag;
        fill = state == WAIT && count == CW'(MEM_LATENCY - 1);
        next = state == LOOKUP ? (hit ? LOOKUP : WAIT) : (fill ? LOOKUP : WAIT);
        instruction = hit ? line[{slot, 5'd0} +: 32] : 32'h0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOOKUP;
            valid <= '0;
            count <= '0;
            memoryAddress <= '0;
        end else begin
            state <= next;
            if (state == LOOKUP && !hit) begin
                memoryAddress <= {pcAddress[31:4], 4'h0};
                fillIndex <= index;
                fillTag <= tag;
                count <= '0;
            end else if (state == WAIT) begin
                count <= count + 1'b1;
            end
            if (fill) valid[fillIndex] <= 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset && fill) begin
            tags[fillIndex] <= fillTag;
            lines[fillIndex] <= memoryLine;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: random and directed fetches checked against a line-residency model.
module tb_instruction_cache;
    localparam int LINES = 16;
    localparam int ML = 6;
    logic clock = 0;
    logic reset = 1;
    logic [31:0] pcAddress = 0;
    logic [127:0] memoryLine;
    logic [31:0] memoryAddress, instruction;
    logic hit, stall;
    instruction_cache #(.LINES(LINES), .MEM_LATENCY(ML)) dut (
        .clock(clock), .reset(reset), .pcAddress(pcAddress), .memoryLine(memoryLine),
        .memoryAddress(memoryAddress), .instruction(instruction), .hit(hit), .stall(stall)
    );
    always #5 clock = ~clock;
    logic [31:0] mem [1024];
    assign memoryLine = {mem[{memoryAddress[11:4], 2'd0}], mem[{memoryAddress[11:4], 2'd1}],
                         mem[{memoryAddress[11:4], 2'd2}], mem[{memoryAddress[11:4], 2'd3}]};
    int checks = 0;
    int errors = 0;
    // model: which 16-byte line is resident per slot, and how many wait edges remain
    bit resValid [LINES];
    logic [27:0] resLine [LINES];
    int busy = 0;
    logic [27:0] pend;
    logic [31:0] expAddr = 0;
    logic obsHit, obsStall;
    logic [31:0] obsInstr;
    task check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    task cycle(input logic [31:0] pc, input bit rst);
        int idx;
        bit eh;
        logic [31:0] ei;
        pcAddress = pc;
        reset = rst;
        @(negedge clock);
        idx = int'(pc[31:4] % LINES);
        eh = busy == 0 && resValid[idx] && resLine[idx] == pc[31:4];
        ei = eh ? mem[pc[11:2]] : 32'h0;
        obsHit = hit;
        obsStall = stall;
        obsInstr = instruction;
        check("hit", {31'b0, hit}, {31'b0, eh});
        check("stall", {31'b0, stall}, {31'b0, !eh});
        check("instr", instruction, ei);
        check("maddr", memoryAddress, expAddr);
        if (rst) begin
            resValid = '{default: 0};
            busy = 0;
            expAddr = 0;
        end else if (busy == 0 && !eh) begin
            pend = pc[31:4];
            busy = ML;
            expAddr = {pc[31:4], 4'h0};
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                resValid[int'(pend % LINES)] = 1;
                resLine[int'(pend % LINES)] = pend;
            end
        end
        @(posedge clock);
        #1;
    endtask
    task until_hit(input logic [31:0] pc, output int n);
        n = 0;
        do begin
            cycle(pc, 0);
            if (obsStall) n++;
        end while (obsStall && n < 40);
    endtask
    initial begin
        int n;
        logic [31:0] pc;
        logic [31:0] pool [4];
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h00430800;
        mem[1] = 32'h00A62001;
        mem[2] = 32'h01093802;
        mem[3] = 32'h016C5003;
        mem[4] = 32'h01CF6804;
        mem[12] = 32'h1800FFF3;
        repeat (2) @(posedge clock);
        #1;
        cycle(0, 1);
        until_hit(0, n);
        check("pen_0", n, 7);
        check("i_0", obsInstr, 32'h00430800);
        cycle(4, 0);
        check("i_4", obsInstr, 32'h00A62001);
        cycle(8, 0);
        check("i_8", obsInstr, 32'h01093802);
        cycle(12, 0);
        check("i_c", obsInstr, 32'h016C5003);
        check("seq_stall", {31'b0, obsStall}, 0);
        until_hit(32'h10, n);
        check("pen_10", n, 7);
        check("i_10", obsInstr, 32'h01CF6804);
        cycle(0, 0);
        check("line0_kept", {31'b0, obsHit}, 1);
        until_hit(32'h100, n);
        check("pen_100", n, 7);
        until_hit(0, n);
        check("conflict_0", n, 7);
        repeat (3) cycle(32'h20, 0);
        until_hit(32'h30, n);
        check("pen_20_30", n, 11);
        check("i_30", obsInstr, 32'h1800FFF3);
        cycle(32'h20, 0);
        check("line20", {31'b0, obsHit}, 1);
        cycle(0, 1);
        repeat (4) cycle(0, 0);
        cycle(0, 1);
        check("abort_nohit", {31'b0, obsHit}, 0);
        until_hit(0, n);
        check("pen_after_abort", n, 7);
        for (int i = 0; i < 4; i++) pool[i] = $urandom_range(0, 4095);
        pc = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1: pc = $urandom_range(0, 4095);
                2, 3, 4, 5: pc = (pc + 4) & 32'hFFF;
                default: pc = pool[$urandom_range(0, 3)] ^ ($urandom_range(0, 3) << 2);
            endcase
            cycle(pc, $urandom_range(0, 299) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 The block SHALL have parameter LINES, default 16, meaning the number of direct-mapped lines (power of two, at least 2).
REQ-002 The block SHALL have parameter MEM_LATENCY, default 6, meaning the number of rising edges the memory address is held before the line is captured (at least 5).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clock, input, 1, rising-edge clock.
REQ-005 Port: reset, input, 1, synchronous active-high reset.
REQ-006 Port: pcAddress, input, 32, CPU fetch byte address; bits [1:0] ignored.
REQ-007 Port: memoryLine, input, 128, 16-byte line returned by the instruction memory.
REQ-008 Port: memoryAddress, output, 32, registered line address to the instruction memory, always 16-byte aligned.
REQ-009 Port: instruction, output, 32, fetched instruction word.
REQ-010 Port: hit, output, 1, instruction is valid this cycle.
REQ-011 Port: stall, output, 1, equal to NOT hit; the CPU holds its PC while stall is 1.

Function
REQ-012 The address split SHALL be: offset = pcAddress[3:0], word = pcAddress[3:2], index = pcAddress[3+log2(LINES):4], tag = the remaining upper bits.
REQ-013 Storage SHALL be LINES entries, each holding a valid bit, a tag and 128 data bits.
REQ-014 The FSM SHALL have exactly two states, LOOKUP and WAIT.
REQ-015 In LOOKUP, hit SHALL be combinational: hit = 1 when valid[index] = 1 and the stored tag equals the tag of pcAddress.
REQ-016 In WAIT, hit SHALL be 0.
REQ-017 Word selection SHALL be big-endian: instruction = line[127-32*word -: 32], so byte offset 0 is in the MSBs.
REQ-018 instruction SHALL be 32'h0 whenever hit = 0.
REQ-019 A miss in LOOKUP SHALL, at that edge, register memoryAddress = {pcAddress[31:4], 4'h0}, latch index and tag, clear the wait counter and enter WAIT.
REQ-020 In WAIT, memoryAddress SHALL be held stable and the counter SHALL increment on each edge.
REQ-021 On the WAIT edge where counter = MEM_LATENCY-1, the block SHALL write memoryLine, the latched tag and valid = 1 into the latched index, and return to LOOKUP.
REQ-022 Miss penalty SHALL be MEM_LATENCY+1 stall cycles; hit is asserted in the first LOOKUP cycle after the fill when pcAddress is unchanged.
REQ-023 Changes on pcAddress during WAIT SHALL be ignored; the fill completes for the latched address, then the current pcAddress is looked up (a new miss is possible).
REQ-024 A conflict miss (same index, different tag) SHALL overwrite the line, with no replacement choice.
REQ-025 Hits SHALL not change memoryAddress, so the memory sees no new block.
REQ-026 Back-to-back hits SHALL sustain one instruction per cycle with stall = 0.

Reset
REQ-027 Reset SHALL clear all valid bits, set state to LOOKUP, and set the counter and memoryAddress to 0.
REQ-028 After reset, hit = 0, stall = 1 and instruction = 0 until the first fill.
REQ-029 Reset asserted during WAIT SHALL abort the fill with no line written; reset has priority over every other action.

Verification
REQ-030 Scenario: reset, then pcAddress=0x0 -> memoryAddress=0x0, stall=1 for 7 cycles, then hit=1 and instruction=32'h00430800.
REQ-031 Scenario: after the line 0 fill, pcAddress=0x4, 0x8, 0xC on consecutive cycles -> stall=0 throughout; instruction=32'h00A62001, 32'h01093802, 32'h016C5003.
REQ-032 Scenario: pcAddress=0x10 -> miss, memoryAddress=0x10, after the penalty instruction=32'h01CF6804; line 0 still hits afterwards.
REQ-033 Scenario: pcAddress=0x100 after line 0 is filled -> conflict miss, memoryAddress=0x100; a following pcAddress=0x0 misses again.
REQ-034 Scenario: pcAddress=0x20 miss, then pcAddress=0x30 at wait count 2 -> line 0x20 is filled, then memoryAddress=0x30 on the next edge and stall stays 1; final instruction=memory bytes 0x30-0x33 (32'h1800FFF3).
REQ-035 Scenario: reset pulsed at wait count 3 during the 0x0 fill -> no hit; pcAddress=0x0 misses again with the full 7-cycle penalty.
